// File: rtl/full_subtractor.sv
// full_subtractor: registered ripple-borrow subtractor, {Borr_out, D} = A - B - C.
// Each bit is a classic full-subtractor cell. The borrow-in C feeds the LSB cell.
// Optional macro FULL_SUBTRACTOR_PIPE_EN adds a second output register stage,
// which gives a latency of 2 instead of 1. The arithmetic is the same either way.
module full_subtractor #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    input  logic             in_valid,
    output logic [WIDTH-1:0] D,
    output logic             Borr_out,
    output logic             out_valid
);

    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] diff;

    logic [WIDTH-1:0] stage1_diff;
    logic             stage1_borrow;
    logic             stage1_valid;

    // Ripple the borrow from the LSB cell up through every bit cell
    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = C;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]       = A[i] ^ B[i] ^ borrow[i];
            borrow[i+1]   = (~A[i] & B[i]) | (~A[i] & borrow[i]) | (B[i] & borrow[i]);
        end
    end

    // First register stage: load only on qualified input so idle or X inputs never leak out
    always_ff @(posedge clk) begin
        if (rst) begin
            stage1_diff   <= '0;
            stage1_borrow <= 1'b0;
            stage1_valid  <= 1'b0;
        end else begin
            stage1_valid <= in_valid;
            if (in_valid) begin
                stage1_diff   <= diff;
                stage1_borrow <= borrow[WIDTH];
            end
        end
    end

`ifdef FULL_SUBTRACTOR_PIPE_EN
    logic [WIDTH-1:0] stage2_diff;
    logic             stage2_borrow;
    logic             stage2_valid;

    // Second register stage: the same hold-unless-valid rule, keyed on the stage-1 valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            stage2_diff   <= '0;
            stage2_borrow <= 1'b0;
            stage2_valid  <= 1'b0;
        end else begin
            stage2_valid <= stage1_valid;
            if (stage1_valid) begin
                stage2_diff   <= stage1_diff;
                stage2_borrow <= stage1_borrow;
            end
        end
    end

    assign D         = stage2_diff;
    assign Borr_out  = stage2_borrow;
    assign out_valid = stage2_valid;
`else
    assign D         = stage1_diff;
    assign Borr_out  = stage1_borrow;
    assign out_valid = stage1_valid;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: scoreboard bench for full_subtractor at WIDTH = 1 and WIDTH = 8.
// Expected results are queued as stimulus is driven. They are popped when the
// expected valid reaches the output, after 1 cycle, or 2 cycles with FULL_SUBTRACTOR_PIPE_EN.
module tb_full_subtractor;

`ifdef FULL_SUBTRACTOR_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;

    logic       a1, b1, c1, v1;
    logic       d1, bo1, ov1;
    logic [7:0] a8, b8;
    logic       c8, v8;
    logic [7:0] d8;
    logic       bo8, ov8;

    int checks = 0;
    int errors = 0;

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    bit         vh1[$];
    bit         vh8[$];
    logic [1:0] hold1;
    logic [8:0] hold8;
    logic       rstAtEdge;

    always #5 clk = ~clk;

    full_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .C(c1), .in_valid(v1),
        .D(d1), .Borr_out(bo1), .out_valid(ov1)
    );

    full_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .C(c8), .in_valid(v8),
        .D(d8), .Borr_out(bo8), .out_valid(ov8)
    );

    task automatic compare(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus1(input logic a, input logic b, input logic c, input logic v,
                                  input logic expD, input logic expB);
        a1 = a; b1 = b; c1 = c; v1 = v;
        if (v && !rst) q1.push_back({expB, expD});
    endtask

    task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c,
                                  input logic v, input logic [7:0] expD, input logic expB);
        a8 = a; b8 = b; c8 = c; v8 = v;
        if (v && !rst) q8.push_back({expB, expD});
    endtask

    task automatic checkOutput(input string tag);
        bit ev1, ev8;
        ev1 = vh1.pop_front();
        ev8 = vh8.pop_front();
        if (rstAtEdge) begin
            if (ev1 && q1.size() > 0) void'(q1.pop_front());
            if (ev8 && q8.size() > 0) void'(q8.pop_front());
            ev1 = 1'b0; ev8 = 1'b0;
            hold1 = '0; hold8 = '0;
        end else begin
            if (ev1) begin
                if (q1.size() == 0) compare({tag, " w1 scoreboard underflow"}, 9'd1, 9'd0);
                else hold1 = q1.pop_front();
            end
            if (ev8) begin
                if (q8.size() == 0) compare({tag, " w8 scoreboard underflow"}, 9'd1, 9'd0);
                else hold8 = q8.pop_front();
            end
        end
        compare({tag, " w1 out_valid"}, {8'd0, ov1}, {8'd0, ev1});
        compare({tag, " w1 D/Borr"}, {7'd0, bo1, d1}, {7'd0, hold1});
        compare({tag, " w8 out_valid"}, {8'd0, ov8}, {8'd0, ev8});
        compare({tag, " w8 D/Borr"}, {bo8, d8}, hold8);
    endtask

    task automatic tick(input string tag);
        vh1.push_back(v1 && !rst);
        vh8.push_back(v8 && !rst);
        rstAtEdge = rst;
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus1(1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b0);
            applyStimulus8(8'hxx, 8'hxx, 1'bx, 1'b0, 8'h00, 1'b0);
            tick(tag);
        end
    endtask

    initial begin
        logic [1:0] r1;
        logic [8:0] r8;
        logic       ra1, rb1, rc1, rv1, rc8, rv8;
        logic [7:0] ra8, rb8;
        logic [2:0] abc;
        logic [1:0] ttExp[8];

        for (int i = 0; i < LAT - 1; i++) begin
            vh1.push_back(1'b0);
            vh8.push_back(1'b0);
        end
        hold1 = '0;
        hold8 = '0;

        // Reset while presenting valid data: nothing may appear
        rst = 1'b1;
        applyStimulus1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus8(8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
        tick("reset");
        tick("reset");
        tick("reset");

        // Release reset with the same inputs: the result follows after the latency
        rst = 1'b0;
        applyStimulus1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus8(8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
        tick("release");

        // Truth table on WIDTH=1 alongside the directed wide cases on WIDTH=8
        ttExp[0] = 2'b00; ttExp[1] = 2'b11; ttExp[2] = 2'b11; ttExp[3] = 2'b10;
        ttExp[4] = 2'b01; ttExp[5] = 2'b00; ttExp[6] = 2'b00; ttExp[7] = 2'b11;
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            applyStimulus1(abc[2], abc[1], abc[0], 1'b1, ttExp[i][0], ttExp[i][1]);
            case (i)
                0: applyStimulus8(8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 1'b1);
                1: applyStimulus8(8'hFF, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
                2: applyStimulus8(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b0);
                default: applyStimulus8(8'hxx, 8'hxx, 1'bx, 1'b0, 8'h00, 1'b0);
            endcase
            tick("directed");
        end

        // Hold: one valid result, then invalid inputs with different values
        applyStimulus1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus8(8'h01, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
        tick("hold load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            applyStimulus8(8'h00, 8'h01, 1'b1, 1'b0, 8'h00, 1'b0);
            tick("hold");
        end

        // Reset in the middle of a stream drops in-flight results
        applyStimulus1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus8(8'h20, 8'h30, 1'b0, 1'b1, 8'hF0, 1'b1);
        tick("midreset pre");
        rst = 1'b1;
        applyStimulus1(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus8(8'h40, 8'h01, 1'b0, 1'b1, 8'h3F, 1'b0);
        tick("midreset");
        rst = 1'b0;
        idle("midreset after", LAT + 1);

        // Random back-to-back traffic with in_valid toggling
        for (int i = 0; i < 1000; i++) begin
            rv1 = 1'($urandom_range(0, 1));
            rv8 = 1'($urandom_range(0, 1));
            ra1 = 1'($urandom); rb1 = 1'($urandom); rc1 = 1'($urandom);
            ra8 = 8'($urandom); rb8 = 8'($urandom); rc8 = 1'($urandom);
            r1 = {1'b0, ra1} - {1'b0, rb1} - {1'b0, rc1};
            r8 = {1'b0, ra8} - {1'b0, rb8} - {8'd0, rc8};
            if (rv1) applyStimulus1(ra1, rb1, rc1, 1'b1, r1[0], r1[1]);
            else     applyStimulus1(1'bx, 1'bx, 1'bx, 1'b0, 1'b0, 1'b0);
            if (rv8) applyStimulus8(ra8, rb8, rc8, 1'b1, r8[7:0], r8[8]);
            else     applyStimulus8(8'hxx, 8'hxx, 1'bx, 1'b0, 8'h00, 1'b0);
            tick("random");
        end

        idle("drain", LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
